// File: rtl/f0_pkg.sv
// Constants and state encoding shared by the capture buffer and the f0 estimator.
package f0_pkg;

  localparam int DATA_W = 12;
  localparam int ADDR_W = 11;
  localparam int DEPTH  = 2048;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_ARM  = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    FILL = ST_FILL,
    ARM  = ST_ARM,
    HOLD = ST_HOLD
  } state_e;

endpackage

// File: rtl/frame_ram.sv
// Frame store: synchronous write, registered read-first read port.
module frame_ram #(
  parameter int DATA_W = f0_pkg::DATA_W,
  parameter int ADDR_W = f0_pkg::ADDR_W,
  parameter int DEPTH  = f0_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] rd_data_r;

  // Write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Registered read; NBA ordering makes a same-address read return old data.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_r <= '0;
    end else begin
      rd_data_r <= mem_r[rd_addr];
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/sample_frame_buffer.sv
// Captures a (decimated) frame of ADC samples, hands it to the f0 estimator
// with a start pulse, and holds it write-protected until the estimator is done.
module sample_frame_buffer #(
  parameter int DATA_W = f0_pkg::DATA_W,
  parameter int ADDR_W = f0_pkg::ADDR_W,
  parameter int DEPTH  = f0_pkg::DEPTH,
  parameter int DECIM  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_in,
  output logic              start,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              est_done,
  output logic              busy,
  output logic [7:0]        frame_cnt,
  output logic              overrun
);

  import f0_pkg::*;

  localparam logic [7:0]        DECIM_LAST = 8'(DECIM - 1);
  localparam logic [ADDR_W-1:0] PTR_LAST   = ADDR_W'(DEPTH - 1);

  state_e            state_r, state_nx_s;
  logic [ADDR_W-1:0] wr_ptr_r, wr_ptr_nx_s;
  logic [7:0]        decim_cnt_r, decim_cnt_nx_s;
  logic              we_s;
  logic              done_q_r;
  logic              done_pend_r;
  logic              done_rise_s;
  logic              start_r;
  logic              busy_r;
  logic [7:0]        frame_cnt_r;
  logic              overrun_r;

  assign done_rise_s = est_done & ~done_q_r;

  // Next-state, write pointer and decimation counter.
  always_comb begin
    state_nx_s     = state_r;
    wr_ptr_nx_s    = wr_ptr_r;
    decim_cnt_nx_s = decim_cnt_r;
    we_s           = 1'b0;
    case (state_r)
      IDLE: begin
        if (en) begin
          state_nx_s     = FILL;
          wr_ptr_nx_s    = '0;
          decim_cnt_nx_s = 8'd0;
        end else begin
          state_nx_s = IDLE;
        end
      end
      FILL: begin
        if (!en) begin
          state_nx_s = IDLE;
        end else if (sample_valid && (decim_cnt_r == DECIM_LAST)) begin
          we_s           = 1'b1;
          decim_cnt_nx_s = 8'd0;
          wr_ptr_nx_s    = wr_ptr_r + ADDR_W'(1);
          if (wr_ptr_r == PTR_LAST) begin
            state_nx_s = ARM;
          end else begin
            state_nx_s = FILL;
          end
        end else if (sample_valid) begin
          decim_cnt_nx_s = decim_cnt_r + 8'd1;
        end else begin
          state_nx_s = FILL;
        end
      end
      ARM: begin
        state_nx_s = HOLD;
      end
      HOLD: begin
        // A done edge seen during ARM is carried in done_pend_r.
        if (done_rise_s || done_pend_r) begin
          wr_ptr_nx_s    = '0;
          decim_cnt_nx_s = 8'd0;
          if (en) begin
            state_nx_s = FILL;
          end else begin
            state_nx_s = IDLE;
          end
        end else begin
          state_nx_s = HOLD;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // State, counters, edge detect and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      wr_ptr_r    <= '0;
      decim_cnt_r <= 8'd0;
      done_q_r    <= 1'b0;
      done_pend_r <= 1'b0;
      start_r     <= 1'b0;
      busy_r      <= 1'b0;
      frame_cnt_r <= 8'd0;
      overrun_r   <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      wr_ptr_r    <= wr_ptr_nx_s;
      decim_cnt_r <= decim_cnt_nx_s;
      done_q_r    <= est_done;
      done_pend_r <= (state_r == ARM) && done_rise_s;
      start_r     <= (state_nx_s == ARM);
      busy_r      <= (state_nx_s != IDLE);
      if (state_nx_s == ARM) begin
        frame_cnt_r <= frame_cnt_r + 8'd1;
      end
      if (sample_valid && en && ((state_r == ARM) || (state_r == HOLD))) begin
        overrun_r <= 1'b1;
      end
    end
  end

  frame_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_frame_ram (
    .clk     (clk),
    .rst     (rst),
    .we      (we_s & ~rst),
    .wr_addr (wr_ptr_r),
    .wr_data (sample_in),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign start     = start_r;
  assign busy      = busy_r;
  assign frame_cnt = frame_cnt_r;
  assign overrun   = overrun_r;

endmodule

// File: tb/tb_sample_frame_buffer.sv
// Scoreboard bench for sample_frame_buffer: one instance with DECIM=1, one with DECIM=4.
module tb_sample_frame_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        en1 = 1'b0, sv1 = 1'b0, done1 = 1'b0;
  logic [11:0] sin1 = 12'd0;
  logic [10:0] ra1 = 11'd0;
  logic        start1, busy1, ovr1;
  logic [11:0] rd_data1;
  logic [7:0]  fc1;

  logic        en4 = 1'b0, sv4 = 1'b0, done4 = 1'b0;
  logic [11:0] sin4 = 12'd0;
  logic [10:0] ra4 = 11'd0;
  logic        start4, busy4, ovr4;
  logic [11:0] rd_data4;
  logic [7:0]  fc4;

  typedef struct {
    bit          inst;
    logic        busy;
    logic [7:0]  fc;
    logic        ov;
    bit          chk_rd;
    logic [11:0] rd;
  } st_t;

  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  int          startq1[$];
  int          startq4[$];
  logic [11:0] rdq1[$];
  logic [11:0] rdq4[$];
  st_t         stq[$];
  bit          rdi1 = 1'b0, rdi4 = 1'b0, rdp1 = 1'b0, rdp4 = 1'b0;

  sample_frame_buffer #(.DECIM(1)) dut1 (
    .clk(clk), .rst(rst), .en(en1), .sample_valid(sv1), .sample_in(sin1),
    .start(start1), .rd_addr(ra1), .rd_data(rd_data1), .est_done(done1),
    .busy(busy1), .frame_cnt(fc1), .overrun(ovr1)
  );

  sample_frame_buffer #(.DECIM(4)) dut4 (
    .clk(clk), .rst(rst), .en(en4), .sample_valid(sv4), .sample_in(sin4),
    .start(start4), .rd_addr(ra4), .rd_data(rd_data4), .est_done(done4),
    .busy(busy4), .frame_cnt(fc4), .overrun(ovr4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    rdp1 <= rdi1;
    rdp4 <= rdi4;
  end

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: start pulses, read data and queued status expectations.
  always @(negedge clk) begin
    if (start1) begin
      if (startq1.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL start1_unexpected: got start=1 at cycle %0d, expected no start", cyc);
      end else begin
        chk("start1_cycle", cyc, startq1.pop_front());
      end
    end
    if (start4) begin
      if (startq4.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL start4_unexpected: got start=1 at cycle %0d, expected no start", cyc);
      end else begin
        chk("start4_cycle", cyc, startq4.pop_front());
      end
    end
    if (rdp1 && (rdq1.size() > 0)) chk("rd_data1", int'(rd_data1), int'(rdq1.pop_front()));
    if (rdp4 && (rdq4.size() > 0)) chk("rd_data4", int'(rd_data4), int'(rdq4.pop_front()));
    while (stq.size() > 0) begin
      st_t s;
      s = stq.pop_front();
      if (s.inst == 1'b0) begin
        chk("busy1", int'(busy1), int'(s.busy));
        chk("frame_cnt1", int'(fc1), int'(s.fc));
        chk("overrun1", int'(ovr1), int'(s.ov));
        if (s.chk_rd) chk("rd_data1_reset", int'(rd_data1), int'(s.rd));
      end else begin
        chk("busy4", int'(busy4), int'(s.busy));
        chk("frame_cnt4", int'(fc4), int'(s.fc));
        chk("overrun4", int'(ovr4), int'(s.ov));
        if (s.chk_rd) chk("rd_data4_reset", int'(rd_data4), int'(s.rd));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_st(bit inst, logic b, logic [7:0] fc, logic ov, bit chk_rd, logic [11:0] rd);
    st_t s;
    s.inst = inst; s.busy = b; s.fc = fc; s.ov = ov; s.chk_rd = chk_rd; s.rd = rd;
    stq.push_back(s);
  endtask

  task automatic rd1(int a, int e);
    ra1 = 11'(a);
    rdi1 = 1'b1;
    rdq1.push_back(12'(e));
    step();
    rdi1 = 1'b0;
  endtask

  task automatic rd4(int a, int e);
    ra4 = 11'(a);
    rdi4 = 1'b1;
    rdq4.push_back(12'(e));
    step();
    rdi4 = 1'b0;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation still running at time limit, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    exp_st(1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 12'd0);
    exp_st(1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 12'd0);

    // Frame 1: ramp 0..2047; start the cycle after the last write.
    en1 = 1'b1; step();
    for (int i = 0; i < 2048; i++) begin sv1 = 1'b1; sin1 = 12'(i); step(); end
    sv1 = 1'b0; startq1.push_back(cyc);
    step();
    exp_st(1'b0, 1'b1, 8'd1, 1'b0, 1'b0, 12'd0);
    for (int a = 0; a < 2048; a++) rd1(a, a);

    // Samples while held are dropped and flag overrun.
    sv1 = 1'b1; sin1 = 12'hABC; step(); step(); sv1 = 1'b0; step();
    exp_st(1'b0, 1'b1, 8'd1, 1'b1, 1'b0, 12'd0);
    rd1(0, 0); rd1(1234, 1234); rd1(2047, 2047);

    // Rising done releases the frame; frame 2 is a descending ramp.
    done1 = 1'b1; step();
    exp_st(1'b0, 1'b1, 8'd1, 1'b1, 1'b0, 12'd0);
    for (int i = 0; i < 2048; i++) begin sv1 = 1'b1; sin1 = 12'(4095 - i); step(); end
    sv1 = 1'b0; startq1.push_back(cyc);
    step();
    exp_st(1'b0, 1'b1, 8'd2, 1'b1, 1'b0, 12'd0);

    // Done still high from before ARM: must stay in HOLD, writes blocked.
    for (int i = 0; i < 4; i++) begin sv1 = 1'b1; sin1 = 12'h555; step(); end
    sv1 = 1'b0;
    rd1(0, 4095); rd1(2047, 2048);
    done1 = 1'b0; step();
    done1 = 1'b1; step();

    // Abort at wr_ptr=1000, then a fresh full frame is required.
    for (int i = 0; i < 1000; i++) begin sv1 = 1'b1; sin1 = 12'h7FF; step(); end
    en1 = 1'b0; sv1 = 1'b1; sin1 = 12'hFFF; step(); sv1 = 1'b0;
    exp_st(1'b0, 1'b0, 8'd2, 1'b1, 1'b0, 12'd0);
    step(); step();
    en1 = 1'b1; step();
    for (int i = 0; i < 2047; i++) begin sv1 = 1'b1; sin1 = 12'(i + 100); step(); end
    sv1 = 1'b0; step(); step();
    exp_st(1'b0, 1'b1, 8'd2, 1'b1, 1'b0, 12'd0);
    sv1 = 1'b1; sin1 = 12'd2147; step(); sv1 = 1'b0; startq1.push_back(cyc);
    step();
    exp_st(1'b0, 1'b1, 8'd3, 1'b1, 1'b0, 12'd0);
    rd1(0, 100); rd1(999, 1099); rd1(2047, 2147);

    // Reset while holding: status clears, RAM contents survive.
    ra1 = 11'd999; rst = 1'b1; step(); rst = 1'b0; en1 = 1'b0;
    exp_st(1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 12'd0);
    rd1(999, 1099);
    step(); step();

    // Decimation by 4: RAM[k] holds strobe 4k+3.
    en4 = 1'b1; step();
    for (int n = 0; n < 8192; n++) begin sv4 = 1'b1; sin4 = 12'(n); step(); end
    sv4 = 1'b0; startq4.push_back(cyc);
    step();
    exp_st(1'b1, 1'b1, 8'd1, 1'b0, 1'b0, 12'd0);
    for (int k = 0; k < 2048; k++) rd4(k, (4 * k + 3) % 4096);
    step(); step();

    chk("start1_pending", startq1.size(), 0);
    chk("start4_pending", startq4.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
